// File: rtl/calc_engine.sv
// Decimal entry, restoring divider and double-dabble display core for the keypad calculator.
// Optional leading-zero blanking is enabled by defining CALC_LEADING_BLANK_EN.
module calc_engine #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  digit_valid,
  input  logic [3:0]            digit_value,
  input  logic                  op_next,
  input  logic                  op_quot,
  input  logic                  op_rem,
  input  logic                  op_clear,
  output logic [4*DIGITS-1:0]   disp_bcd,
  output logic                  busy,
  output logic                  err,
  output logic [2:0]            state
);

  localparam int unsigned NB = 4 * DIGITS;
  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam int unsigned SW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    ENTER_B = 3'd1,
    DIVIDE  = 3'd2,
    CONVERT = 3'd3,
    SHOW    = 3'd4,
    ERROR   = 3'd5
  } state_e;

  // All state lives in one record so clear and reset share the all-zero image.
  typedef struct packed {
    state_e            state;
    logic [WIDTH-1:0]  a_acc;
    logic [NB-1:0]     a_bcd;
    logic [CW-1:0]     a_cnt;
    logic [WIDTH-1:0]  b_acc;
    logic [NB-1:0]     b_bcd;
    logic [CW-1:0]     b_cnt;
    logic              sel;
    logic [WIDTH-1:0]  quot;
    logic [WIDTH-1:0]  rem;
    logic [WIDTH-1:0]  dq;
    logic [WIDTH-1:0]  dr;
    logic [WIDTH-1:0]  cbin;
    logic [NB-1:0]     cbcd;
    logic [SW-1:0]     step;
    logic [NB-1:0]     disp;
    logic              busy;
    logic              err;
  } regs_t;

  regs_t r_q, r_d;

  function automatic logic [NB-1:0] fmt(input logic [NB-1:0] v);
`ifdef CALC_LEADING_BLANK_EN
    logic          lead;
    logic [NB-1:0] o;
    lead = 1'b1;
    o    = v;
    for (int unsigned i = DIGITS - 1; i > 0; i--) begin
      if (lead && v[4*i +: 4] == 4'd0) o[4*i +: 4] = 4'hF;
      else                              lead = 1'b0;
    end
    return o;
`else
    return v;
`endif
  endfunction

  logic             digit_ok;
  logic [WIDTH-1:0] a_acc_nx, b_acc_nx;
  logic [NB-1:0]    a_bcd_nx, b_bcd_nx;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] dq_nx, dr_nx;
  logic [NB-1:0]    cbcd_adj, cbcd_nx;
  logic [WIDTH-1:0] cbin_nx;
  logic             last_step;

  assign digit_ok  = digit_valid && (digit_value <= 4'd9);
  assign a_acc_nx  = (r_q.a_acc << 3) + (r_q.a_acc << 1) + WIDTH'(digit_value);
  assign b_acc_nx  = (r_q.b_acc << 3) + (r_q.b_acc << 1) + WIDTH'(digit_value);
  assign a_bcd_nx  = NB'({r_q.a_bcd, digit_value});
  assign b_bcd_nx  = NB'({r_q.b_bcd, digit_value});
  assign last_step = (r_q.step == SW'(WIDTH - 1));

  // Restoring division step: shift in the next dividend bit, subtract if it fits.
  assign shifted = {r_q.dr, r_q.dq[WIDTH-1]};
  assign ge      = (shifted >= {1'b0, r_q.b_acc});
  assign dq_nx   = {r_q.dq[WIDTH-2:0], ge};
  assign dr_nx   = ge ? WIDTH'(shifted - {1'b0, r_q.b_acc}) : shifted[WIDTH-1:0];

  always_comb begin
    cbcd_adj = r_q.cbcd;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r_q.cbcd[4*i +: 4] >= 4'd5) cbcd_adj[4*i +: 4] = r_q.cbcd[4*i +: 4] + 4'd3;
    end
  end

  assign {cbcd_nx, cbin_nx} = (NB + WIDTH)'({cbcd_adj, r_q.cbin} << 1);

  always_comb begin
    r_d = r_q;
    unique case (r_q.state)
      ENTER_A: begin
        if (op_next) begin
          r_d.state = ENTER_B;
          r_d.disp  = fmt(r_q.b_bcd);
        end else if (digit_ok && r_q.a_cnt < CW'(DIGITS)) begin
          r_d.a_acc = a_acc_nx;
          r_d.a_bcd = a_bcd_nx;
          r_d.a_cnt = r_q.a_cnt + 1'b1;
          r_d.disp  = fmt(a_bcd_nx);
        end
      end
      ENTER_B: begin
        if (op_quot || op_rem) begin
          r_d.sel = !op_quot;
          if (r_q.b_acc == '0) begin
            r_d.state = ERROR;
            r_d.err   = 1'b1;
            r_d.disp  = {DIGITS{4'hE}};
          end else begin
            r_d.state = DIVIDE;
            r_d.busy  = 1'b1;
            r_d.dq    = r_q.a_acc;
            r_d.dr    = '0;
            r_d.step  = '0;
          end
        end else if (digit_ok && r_q.b_cnt < CW'(DIGITS)) begin
          r_d.b_acc = b_acc_nx;
          r_d.b_bcd = b_bcd_nx;
          r_d.b_cnt = r_q.b_cnt + 1'b1;
          r_d.disp  = fmt(b_bcd_nx);
        end
      end
      DIVIDE: begin
        r_d.dq   = dq_nx;
        r_d.dr   = dr_nx;
        r_d.step = r_q.step + 1'b1;
        if (last_step) begin
          r_d.quot  = dq_nx;
          r_d.rem   = dr_nx;
          r_d.cbin  = r_q.sel ? dr_nx : dq_nx;
          r_d.cbcd  = '0;
          r_d.step  = '0;
          r_d.state = CONVERT;
        end
      end
      CONVERT: begin
        r_d.cbin = cbin_nx;
        r_d.cbcd = cbcd_nx;
        r_d.step = r_q.step + 1'b1;
        if (last_step) begin
          r_d.disp  = fmt(cbcd_nx);
          r_d.step  = '0;
          r_d.busy  = 1'b0;
          r_d.state = SHOW;
        end
      end
      SHOW: begin
        if (op_quot || op_rem) begin
          r_d.sel   = !op_quot;
          r_d.cbin  = op_quot ? r_q.quot : r_q.rem;
          r_d.cbcd  = '0;
          r_d.step  = '0;
          r_d.busy  = 1'b1;
          r_d.state = CONVERT;
        end
      end
      ERROR: ;
      default: r_d.state = ENTER_A;
    endcase
    if (op_clear) r_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) r_q <= '0;
    else       r_q <= r_d;
  end

  assign disp_bcd = r_q.disp;
  assign busy     = r_q.busy;
  assign err      = r_q.err;
  assign state    = r_q.state;

endmodule

// File: tb/tb_calc_engine.sv
// Directed, table-driven bench for calc_engine (DIGITS=3, WIDTH=10).
module tb_calc_engine;
  localparam int DIGITS = 3;
  localparam int WIDTH  = 10;

  logic        clk = 1'b0;
  logic        reset, digit_valid, op_next, op_quot, op_rem, op_clear;
  logic [3:0]  digit_value;
  logic [11:0] disp_bcd;
  logic        busy, err;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  calc_engine #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .digit_valid(digit_valid), .digit_value(digit_value),
    .op_next(op_next), .op_quot(op_quot), .op_rem(op_rem), .op_clear(op_clear),
    .disp_bcd(disp_bcd), .busy(busy), .err(err), .state(state)
  );

  typedef struct {
    logic [19:0] ad;
    int          an;
    logic [11:0] exp_a;
    logic [19:0] bd;
    int          bn;
    int          op;      // 0 quot, 1 rem, 2 both
    logic [11:0] exp_disp;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [11:0] efmt(input logic [11:0] v);
`ifdef CALC_LEADING_BLANK_EN
    logic [11:0] r;
    r = v;
    if (v[11:8] == 4'd0) begin
      r[11:8] = 4'hF;
      if (v[7:4] == 4'd0) r[7:4] = 4'hF;
    end
    return r;
`else
    return v;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_digit(input logic [3:0] d);
    digit_value = d;
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
  endtask

  // 0 next, 1 quot, 2 rem, 3 clear, 4 quot+rem, 5 reset
  task automatic pulse(input int which);
    op_next  = (which == 0);
    op_quot  = (which == 1) || (which == 4);
    op_rem   = (which == 2) || (which == 4);
    op_clear = (which == 3);
    reset    = (which == 5);
    tick();
    {op_next, op_quot, op_rem, op_clear, reset} = '0;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic enter(input logic [19:0] ad, input int an, input logic [19:0] bd, input int bn);
    for (int i = an - 1; i >= 0; i--) send_digit(ad[4*i +: 4]);
    pulse(0);
    for (int i = bn - 1; i >= 0; i--) send_digit(bd[4*i +: 4]);
  endtask

  initial begin
    int n;
    {reset, digit_valid, op_next, op_quot, op_rem, op_clear} = '0;
    digit_value = 4'd0;

    vecs[0]  = '{20'h00127, 3, 12'h127, 20'h5,   1, 0, 12'h025, 1'b0};
    vecs[1]  = '{20'h00127, 3, 12'h127, 20'h5,   1, 1, 12'h002, 1'b0};
    vecs[2]  = '{20'h00200, 3, 12'h200, 20'h7,   1, 2, 12'h028, 1'b0};
    vecs[3]  = '{20'h00200, 3, 12'h200, 20'h7,   1, 1, 12'h004, 1'b0};
    vecs[4]  = '{20'h9999B, 5, 12'h999, 20'h1,   1, 0, 12'h999, 1'b0};
    vecs[5]  = '{20'h00000, 0, 12'h000, 20'h9,   1, 0, 12'h000, 1'b0};
    vecs[6]  = '{20'h00005, 1, 12'h005, 20'h999, 3, 1, 12'h005, 1'b0};
    vecs[7]  = '{20'h00042, 2, 12'h042, 20'h0,   1, 0, 12'hEEE, 1'b1};
    vecs[8]  = '{20'h00999, 3, 12'h999, 20'h999, 3, 0, 12'h001, 1'b0};
    vecs[9]  = '{20'h00998, 3, 12'h998, 20'h3,   1, 0, 12'h332, 1'b0};
    vecs[10] = '{20'h00998, 3, 12'h998, 20'h3,   1, 1, 12'h002, 1'b0};
    vecs[11] = '{20'h00007, 3, 12'h007, 20'h2,   1, 0, 12'h003, 1'b0};

    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_state", state, 0);
    chk("reset_disp", disp_bcd, 0);
    chk("reset_busy", busy, 0);
    chk("reset_err", err, 0);

    for (int k = 0; k < 12; k++) begin
      pulse(3);
      for (int i = vecs[k].an - 1; i >= 0; i--) send_digit(vecs[k].ad[4*i +: 4]);
      chk($sformatf("v%0d_a_disp", k), disp_bcd, efmt(vecs[k].exp_a));
      pulse(0);
      chk($sformatf("v%0d_enter_b", k), state, 1);
      chk($sformatf("v%0d_b_blank", k), disp_bcd, efmt(12'h000));
      for (int i = vecs[k].bn - 1; i >= 0; i--) send_digit(vecs[k].bd[4*i +: 4]);
      pulse(vecs[k].op == 0 ? 1 : (vecs[k].op == 1 ? 2 : 4));
      wait_busy(n);
      chk($sformatf("v%0d_busy_cycles", k), n, vecs[k].exp_err ? 0 : 2 * WIDTH);
      chk($sformatf("v%0d_state", k), state, vecs[k].exp_err ? 5 : 4);
      chk($sformatf("v%0d_disp", k), disp_bcd,
          vecs[k].exp_err ? vecs[k].exp_disp : efmt(vecs[k].exp_disp));
      chk($sformatf("v%0d_err", k), err, vecs[k].exp_err);
    end

    // Remainder then re-select quotient from SHOW.
    pulse(3);
    enter(20'h127, 3, 20'h5, 1);
    pulse(2);
    wait_busy(n);
    chk("rs_rem", disp_bcd, efmt(12'h002));
    pulse(1);
    wait_busy(n);
    chk("rs_busy", n, WIDTH);
    chk("rs_quot", disp_bcd, efmt(12'h025));
    send_digit(4'd3);
    pulse(0);
    chk("show_ignore_state", state, 4);
    chk("show_ignore_disp", disp_bcd, efmt(12'h025));

    // ERROR is sticky until clear.
    pulse(3);
    enter(20'h42, 2, 20'h0, 1);
    pulse(1);
    chk("err_state", state, 5);
    send_digit(4'd1);
    pulse(1);
    pulse(0);
    chk("err_sticky_state", state, 5);
    chk("err_sticky_disp", disp_bcd, 12'hEEE);
    pulse(3);
    chk("err_clr_state", state, 0);
    chk("err_clr_err", err, 0);
    chk("err_clr_disp", disp_bcd, 0);

    // Operation pulses are ignored in ENTER_A.
    send_digit(4'd3);
    pulse(1);
    chk("a_quot_ignored", state, 0);
    chk("a_quot_disp", disp_bcd, efmt(12'h003));

    // Clear at DIVIDE cycle 3.
    pulse(3);
    enter(20'h127, 3, 20'h5, 1);
    pulse(1);
    tick();
    tick();
    chk("abort_in_divide", state, 2);
    pulse(3);
    chk("abort_state", state, 0);
    chk("abort_busy", busy, 0);
    chk("abort_disp", disp_bcd, 0);

    // Reset in the middle of CONVERT.
    enter(20'h127, 3, 20'h5, 1);
    pulse(1);
    for (int i = 0; i < WIDTH + 2; i++) tick();
    chk("rst_in_convert", state, 3);
    pulse(5);
    chk("rst_state", state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_disp", disp_bcd, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
